// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with one outstanding access, fixed latency and zero-fill after reset
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake; req_write, req_addr, req_wdata captured on accept
//   resp_valid/resp_ready    response handshake; resp_rdata, resp_err held until accepted
//   init_done                high once the post-reset zero-fill has finished
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {CLEAR, IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [AW-1:0] clr_idx;
    logic [CW-1:0] cnt;
    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          bad;
    logic [AW-1:0] idx;

    // any address bit above the word index means the access is out of range
    assign bad = (|cap_addr[1:0]) || (|cap_addr[31:AW+2]);
    assign idx = cap_addr[AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    mem[clr_idx] <= '0;
                    clr_idx      <= clr_idx + 1'b1;
                    if (clr_idx == AW'(DEPTH_WORDS - 1)) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= bad;
                        resp_rdata <= (!bad && !cap_write) ? mem[idx] : '0;
                        if (!bad && cap_write) mem[idx] <= cap_wdata;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
